sys_mem_ctrl: RTL and testbench

SYS_MEM_CTRL -- requirements
Module: sys_mem_ctrl

---
 rtl/pkg_mem_types.sv | 16 +
 rtl/mem_wait_cnt.sv | 29 ++
 rtl/sys_mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sys_mem_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_mem_types.sv
// Shared types and default constants for the single-port memory controller.
package pkg_mem_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam int unsigned DEF_ADDR_WIDTH  = 32;
  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_DEPTH_WORDS = 1024;
  localparam int unsigned DEF_WAIT_STATES = 1;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable down-counter that pauses at zero and reports a zero flag.
module mem_wait_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/sys_mem_ctrl.sv
// Word-organised memory with byte-lane writes and a fixed wait-state count.
// Optional address error reporting is enabled with the MEM_ERR_EN macro.
module sys_mem_ctrl
  import pkg_mem_types::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    mem_req,
  input  logic                    mem_wr_en,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  output logic                    mem_ready,
`ifdef MEM_ERR_EN
  output logic                    mem_err,
`endif
  output mem_state_e              dbg_state_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);

  mem_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [BE_W-1:0]       be_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ready_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic                  cnt_load;
  logic                  cnt_dec;
  logic [CNT_W-1:0]      cnt_val;
  logic                  cnt_zero;

  logic                  acc_fire;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_wr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [BE_W-1:0]       acc_be;
  logic [IDX_W-1:0]      acc_idx;
  logic                  acc_ok;
  logic                  unused_addr;

  mem_wait_cnt #(.W(CNT_W)) u_cnt (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .load_i     (cnt_load),
    .load_val_i (WS_INIT),
    .dec_i      (cnt_dec),
    .count_o    (cnt_val),
    .zero_o     (cnt_zero)
  );

  // The access happens on the edge that enters RESP, so data and ready
  // appear together; with no wait states that edge is the accepting one.
  always_comb begin
    acc_fire = 1'b0;
    acc_addr = addr_q;
    acc_wr   = wr_q;
    acc_data = data_q;
    acc_be   = be_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          cnt_load = 1'b1;
          acc_addr = mem_addr;
          acc_wr   = mem_wr_en;
          acc_data = mem_data_in;
          acc_be   = mem_be;
          acc_fire = (WAIT_STATES == 0);
        end
      end
      WAIT: begin
        cnt_dec  = 1'b1;
        acc_fire = cnt_zero || (cnt_val == CNT_W'(1));
      end
      default: ;
    endcase
  end

  assign acc_idx     = acc_addr[IDX_W+1:2];
  assign unused_addr = ^acc_addr;

`ifdef MEM_ERR_EN
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);
  assign acc_ok = (acc_addr[1:0] == 2'b00) && ({1'b0, acc_addr} < ADDR_LIMIT);
`else
  assign acc_ok = 1'b1;
`endif

  // Storage has no reset; a reset edge also blocks any write in flight.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && acc_fire && acc_wr && acc_ok) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (acc_be[i]) mem_q[acc_idx][i*8 +: 8] <= acc_data[i*8 +: 8];
      end
    end
  end

`ifdef MEM_ERR_EN
  logic err_q;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
`ifdef MEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef MEM_ERR_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            addr_q  <= mem_addr;
            wr_q    <= mem_wr_en;
            data_q  <= mem_data_in;
            be_q    <= mem_be;
            state_q <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT:    if (acc_fire) state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (acc_fire) begin
        ready_q <= 1'b1;
        if (!acc_wr) rdata_q <= acc_ok ? mem_q[acc_idx] : '0;
`ifdef MEM_ERR_EN
        err_q   <= !acc_ok;
`endif
      end
    end
  end

  assign mem_data_out = rdata_q;
  assign mem_ready    = ready_q;
  assign dbg_state_o  = state_q;
`ifdef MEM_ERR_EN
  assign mem_err      = err_q;
`endif

endmodule

// File: tb/tb_sys_mem_ctrl.sv
// Directed scoreboard bench: instance 0 has two wait states, instance 1 none.
// Handshake: a request is accepted when mem_req=1 at an edge in IDLE; mem_ready pulses once per accepted request.
module tb_sys_mem_ctrl;
  import pkg_mem_types::*;

  localparam int W = 32;

  typedef struct {
    logic         is_rd;
    logic [W-1:0] data;
    int           cyc;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         req  [2];
  logic         wr   [2];
  logic [31:0]  addr [2];
  logic [W-1:0] din  [2];
  logic [W-1:0] dout [2];
  logic [3:0]   be   [2];
  logic         rdy  [2];
  logic         err  [2];
  mem_state_e   st   [2];

  int n_tests = 0;
  int n_fail  = 0;

  exp_t         q0[$];
  exp_t         q1[$];
  logic [W-1:0] last_rd [2];

  sys_mem_ctrl #(.WAIT_STATES(2)) u_ws2 (
    .sys_clk(clk), .sys_rst(rst), .mem_req(req[0]), .mem_wr_en(wr[0]),
    .mem_addr(addr[0]), .mem_data_in(din[0]), .mem_be(be[0]),
    .mem_data_out(dout[0]), .mem_ready(rdy[0]),
`ifdef MEM_ERR_EN
    .mem_err(err[0]),
`endif
    .dbg_state_o(st[0])
  );

  sys_mem_ctrl #(.WAIT_STATES(0)) u_ws0 (
    .sys_clk(clk), .sys_rst(rst), .mem_req(req[1]), .mem_wr_en(wr[1]),
    .mem_addr(addr[1]), .mem_data_in(din[1]), .mem_be(be[1]),
    .mem_data_out(dout[1]), .mem_ready(rdy[1]),
`ifdef MEM_ERR_EN
    .mem_err(err[1]),
`endif
    .dbg_state_o(st[1])
  );

`ifndef MEM_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  function automatic int ws(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: pops one expectation per mem_ready pulse.
  task automatic mon_pop(input int k);
    exp_t e;
    if (qsize(k) == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL spurious_ready: inst %0d ready=1 at cycle %0d, required no pulse", k, cyc);
      return;
    end
    e = (k == 0) ? q0.pop_front() : q1.pop_front();
    check("ready_cycle", W'(cyc), W'(e.cyc));
`ifdef MEM_ERR_EN
    check("err_flag", W'(err[k]), W'(e.err));
`endif
    if (e.is_rd) begin
      check("rd_data", dout[k], e.data);
      last_rd[k] = e.data;
    end else begin
      check("dout_hold", dout[k], last_rd[k]);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        last_rd[k] = '0;
        check("ready_in_reset", W'(rdy[k]), '0);
      end else if (rdy[k]) begin
        mon_pop(k);
      end
    end
  end

  task automatic wait_done(input int k);
    int t = 0;
    while (qsize(k) != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (qsize(k) != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: inst %0d has %0d pending responses, required 0", k, qsize(k));
      if (k == 0) q0.delete();
      else        q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [W-1:0] d,
                     input logic [3:0] b, input logic [W-1:0] exp_d, input logic exp_e,
                     input logic toggle);
    exp_t e;
    @(negedge clk);
    req[k] = 1'b1; wr[k] = w; addr[k] = a; din[k] = d; be[k] = b;
    e.is_rd = !w; e.data = exp_d; e.err = exp_e; e.cyc = cyc + 1 + ws(k);
    push(k, e);
    @(negedge clk);
    if (toggle) begin
      repeat (ws(k) + 1) begin
        req[k]  = 1'($urandom_range(0, 1));
        addr[k] = $urandom_range(0, 32'h0000_0fff);
        din[k]  = $urandom;
        wr[k]   = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    req[k] = 1'b0;
    wait_done(k);
  endtask

  initial begin
    exp_t e1;
    exp_t e2;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; din[k] = '0; be[k] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_dout0", dout[0], '0);
    check("reset_dout1", dout[1], '0);
    rst = 1'b0;
    @(negedge clk);

    // Two wait states: write then read back.
    txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 'x, 0, 0);
    txn(0, 0, 32'h10, '0, 4'h0, 32'hDEADBEEF, 0, 0);

    // Byte-lane merge.
    txn(0, 1, 32'h20, 32'h11223344, 4'hF, 'x, 0, 0);
    txn(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 'x, 0, 0);
    txn(0, 0, 32'h20, '0, 4'h0, 32'h11BB33DD, 0, 0);

    // Reset during WAIT of a write discards it.
    txn(0, 1, 32'h30, 32'h0, 4'hF, 'x, 0, 0);
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h30; din[0] = 32'hFFFFFFFF; be[0] = 4'hF;
    @(negedge clk);
    req[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_dout", dout[0], '0);
    check("mid_reset_state", W'(st[0]), W'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    txn(0, 0, 32'h30, '0, 4'h0, 32'h0, 0, 0);

    // Inputs toggled while busy are ignored.
    txn(0, 0, 32'h10, '0, 4'h0, 32'hDEADBEEF, 0, 1);
    txn(0, 1, 32'h20, 32'h55667788, 4'hF, 'x, 0, 1);
    txn(0, 0, 32'h20, '0, 4'h0, 32'h55667788, 0, 0);

    // be=0 completes without changing the word.
    txn(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 'x, 0, 0);
    txn(0, 0, 32'h10, '0, 4'h0, 32'hDEADBEEF, 0, 0);

`ifdef MEM_ERR_EN
    txn(0, 1, 32'h0, 32'hC0FFEE00, 4'hF, 'x, 0, 0);
    txn(0, 0, 32'h1002, '0, 4'h0, 32'h0, 1, 0);
    txn(0, 1, 32'h1000, 32'h12345678, 4'hF, 'x, 1, 0);
    txn(0, 0, 32'h13, '0, 4'h0, 32'h0, 1, 0);
    txn(0, 0, 32'h0, '0, 4'h0, 32'hC0FFEE00, 0, 0);
`else
    // Low address bits ignored; high bits wrap by truncation.
    txn(0, 0, 32'h13, '0, 4'h0, 32'hDEADBEEF, 0, 0);
    txn(0, 1, 32'h1040, 32'h00000055, 4'hF, 'x, 0, 0);
    txn(0, 0, 32'h40, '0, 4'h0, 32'h00000055, 0, 0);
`endif

    // No wait states: setup, then back-to-back reads with req held high.
    txn(1, 1, 32'h0, 32'h000000A0, 4'hF, 'x, 0, 0);
    txn(1, 1, 32'h4, 32'h000000B4, 4'hF, 'x, 0, 0);
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h0; be[1] = 4'h0;
    e1.is_rd = 1'b1; e1.data = 32'hA0; e1.err = 1'b0; e1.cyc = cyc + 1;
    e2.is_rd = 1'b1; e2.data = 32'hB4; e2.err = 1'b0; e2.cyc = cyc + 3;
    push(1, e1);
    push(1, e2);
    @(negedge clk);
    addr[1] = 32'h4;
    repeat (2) @(negedge clk);
    req[1] = 1'b0;
    wait_done(1);

    // Read immediately after a write to the same word.
    txn(1, 1, 32'h8, 32'hCAFEF00D, 4'hF, 'x, 0, 0);
    txn(1, 0, 32'h8, '0, 4'h0, 32'hCAFEF00D, 0, 0);
    txn(1, 1, 32'h8, 32'h00001100, 4'b0010, 'x, 0, 0);
    txn(1, 0, 32'h8, '0, 4'h0, 32'hCAFE110D, 0, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
